// File: rtl/icache_fetch.sv
// Direct-mapped, read-only instruction cache for the fetch port.
// Hits return instr combinationally; misses refill a whole line over a req/rvalid handshake.
module icache_fetch #(
   parameter int LINES = 16,
   parameter int WORDS = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] pc,
   output logic [31:0] instr,
   output logic        stall,
   input  logic        flush,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic [31:0] mem_rdata,
   input  logic        mem_rvalid
);

   localparam int OFF_W  = $clog2(WORDS);
   localparam int IDX_W  = $clog2(LINES);
   localparam int TAG_W  = 30 - OFF_W - IDX_W;
   localparam int LINE_W = TAG_W + IDX_W;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      REFILL = 1'b1
   } state_t;

   state_t             state_r;
   state_t             state_nxt_s;
   logic [LINES-1:0]   valid_r;
   logic [TAG_W-1:0]   tag_mem_r  [LINES];
   logic [31:0]        data_mem_r [LINES*WORDS];
   logic [LINE_W-1:0]  line_r;
   logic [OFF_W-1:0]   cnt_r;
   logic               kill_r;

   logic [OFF_W-1:0]   pc_off_s;
   logic [IDX_W-1:0]   pc_idx_s;
   logic [TAG_W-1:0]   pc_tag_s;
   logic [LINE_W-1:0]  pc_line_s;
   logic [IDX_W-1:0]   fill_idx_s;
   logic [TAG_W-1:0]   fill_tag_s;
   logic               hit_s;
   logic               last_s;
   logic               word_done_s;
   logic               unused_pc_bits;

   assign pc_off_s    = pc[OFF_W+1:2];
   assign pc_idx_s    = pc[OFF_W+IDX_W+1:OFF_W+2];
   assign pc_tag_s    = pc[31:OFF_W+IDX_W+2];
   assign pc_line_s   = pc[31:OFF_W+2];
   assign unused_pc_bits = ^pc[1:0];

   assign fill_idx_s  = line_r[IDX_W-1:0];
   assign fill_tag_s  = line_r[LINE_W-1:IDX_W];
   assign hit_s       = valid_r[pc_idx_s] && (tag_mem_r[pc_idx_s] == pc_tag_s);
   assign last_s      = (cnt_r == OFF_W'(WORDS-1));
   assign word_done_s = (state_r == REFILL) && mem_rvalid;

   // Next-state and fetch/memory outputs; reset forces a stall with instr=0.
   always_comb begin
      state_nxt_s = state_r;
      stall       = 1'b1;
      instr       = 32'd0;
      mem_req     = 1'b0;
      mem_addr    = 32'd0;
      case (state_r)
         IDLE: begin
            if (hit_s && reset) begin
               stall = 1'b0;
               instr = data_mem_r[{pc_idx_s, pc_off_s}];
            end else begin
               state_nxt_s = REFILL;
            end
         end
         REFILL: begin
            mem_req  = 1'b1;
            mem_addr = {line_r, cnt_r, 2'b00};
            if (word_done_s && last_s) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = REFILL;
            end
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // Control state: FSM, valid bits, refill line/counter and the flush kill flag.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r <= IDLE;
         valid_r <= {LINES{1'b0}};
         line_r  <= {LINE_W{1'b0}};
         cnt_r   <= {OFF_W{1'b0}};
         kill_r  <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         // flush has priority so a flush on the final beat leaves the line invalid
         if (flush) begin
            valid_r <= {LINES{1'b0}};
         end else if ((state_r == IDLE) && !hit_s) begin
            valid_r[pc_idx_s] <= 1'b0;
         end else if (word_done_s && last_s && !kill_r) begin
            valid_r[fill_idx_s] <= 1'b1;
         end
         if (state_r == IDLE) begin
            kill_r <= 1'b0;
            if (!hit_s) begin
               line_r <= pc_line_s;
               cnt_r  <= {OFF_W{1'b0}};
            end
         end else begin
            if (word_done_s && last_s) begin
               kill_r <= 1'b0;
            end else if (flush) begin
               kill_r <= 1'b1;
            end
            if (word_done_s) begin
               cnt_r <= cnt_r + OFF_W'(1);
            end
         end
      end
   end

   // Data and tag arrays are never reset; only the valid bits qualify them.
   always_ff @(posedge clk) begin
      if (word_done_s) begin
         data_mem_r[{fill_idx_s, cnt_r}] <= mem_rdata;
         if (last_s) begin
            tag_mem_r[fill_idx_s] <= fill_tag_s;
         end
      end
   end

endmodule

// File: tb/tb_icache_fetch.sv
// Directed bench for icache_fetch: a waitable memory responder plus a linear stimulus sequence.
module tb_icache_fetch;

   localparam int WORDS = 4;

   logic        clk;
   logic        reset;
   logic [31:0] pc;
   logic [31:0] instr;
   logic        stall;
   logic        flush;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic [31:0] mem_rdata;
   logic        mem_rvalid;

   int checks    = 0;
   int failures  = 0;
   int wait_cyc  = 0;
   int wcnt      = 0;

   icache_fetch #(.LINES(16), .WORDS(WORDS)) dut (
      .clk(clk), .reset(reset), .pc(pc), .instr(instr), .stall(stall),
      .flush(flush), .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h0000_0000: mem_word = 32'h2008_0001;
         32'h0000_0004: mem_word = 32'h2009_0002;
         32'h0000_0008: mem_word = 32'h0109_5020;
         32'h0000_000C: mem_word = 32'hAC0A_0000;
         default:       mem_word = a ^ 32'h5A5A_0000;
      endcase
   endfunction

   // Backing memory: answers each request after wait_cyc idle cycles.
   initial begin
      mem_rvalid = 1'b0;
      mem_rdata  = 32'd0;
      forever begin
         @(negedge clk);
         #2;
         if (mem_req === 1'b1) begin
            if (wcnt >= wait_cyc) begin
               mem_rvalid = 1'b1;
               mem_rdata  = mem_word(mem_addr);
               wcnt       = 0;
            end else begin
               mem_rvalid = 1'b0;
               wcnt       = wcnt + 1;
            end
         end else begin
            mem_rvalid = 1'b0;
            wcnt       = 0;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic next();
      @(negedge clk);
      #3;
   endtask

   task automatic step(input logic [31:0] a);
      next();
      pc    = a;
      flush = 1'b0;
      #1;
   endtask

   task automatic expect_hit(input string tag, input logic [31:0] a);
      step(a);
      chk({tag, "_stall"}, {31'd0, stall}, 32'd0);
      chk({tag, "_instr"}, instr, mem_word(a));
      chk({tag, "_req"}, {31'd0, mem_req}, 32'd0);
   endtask

   // Starts in an IDLE miss cycle for base; walks every REFILL cycle of the line.
   task automatic fill(input logic [31:0] base, input int waitc,
                       input logic [31:0] redirect, input int flush_w);
      wait_cyc = waitc;
      chk("miss_stall", {31'd0, stall}, 32'd1);
      chk("miss_instr", instr, 32'd0);
      chk("miss_req", {31'd0, mem_req}, 32'd0);
      for (int w = 0; w < WORDS; w++) begin
         for (int k = 0; k <= waitc; k++) begin
            next();
            pc    = (w >= 2) ? redirect : base;
            flush = (w == flush_w) && (k == 0);
            #1;
            chk("refill_stall", {31'd0, stall}, 32'd1);
            chk("refill_req", {31'd0, mem_req}, 32'd1);
            chk("refill_addr", mem_addr, base + 32'(4 * w));
         end
      end
   endtask

   initial begin
      reset = 1'b0;
      pc    = 32'd0;
      flush = 1'b0;
      next();
      chk("rst_stall", {31'd0, stall}, 32'd1);
      chk("rst_instr", instr, 32'd0);
      next();
      chk("rst_req", {31'd0, mem_req}, 32'd0);
      chk("rst_addr", mem_addr, 32'd0);

      // cold miss then sequential hits
      next();
      reset = 1'b1;
      pc    = 32'h0;
      #1;
      fill(32'h0, 0, 32'h0, -1);
      expect_hit("cold", 32'h0);
      expect_hit("seq4", 32'h4);
      expect_hit("seq8", 32'h8);
      expect_hit("seqC", 32'hC);

      // conflict on index 0 with 3-cycle memory latency
      step(32'h100);
      fill(32'h100, 3, 32'h100, -1);
      expect_hit("conf100", 32'h100);
      step(32'h0);
      fill(32'h0, 0, 32'h0, -1);
      expect_hit("refill0", 32'h0);
      step(32'h100);
      chk("alias_miss", {31'd0, stall}, 32'd1);
      fill(32'h100, 0, 32'h100, -1);
      step(32'h0);
      fill(32'h0, 0, 32'h0, -1);

      // redirect to 0x80 after word 1 of the 0x40 refill
      step(32'h40);
      fill(32'h40, 0, 32'h80, -1);
      step(32'h80);
      fill(32'h80, 1, 32'h80, -1);
      expect_hit("redir80", 32'h80);
      expect_hit("redir40", 32'h40);
      expect_hit("redir44", 32'h44);

      // flush in IDLE: current cycle still hits, next cycle misses
      next();
      pc    = 32'h0;
      flush = 1'b1;
      #1;
      chk("flush_idle_stall", {31'd0, stall}, 32'd0);
      chk("flush_idle_instr", instr, 32'h2008_0001);
      step(32'h0);
      chk("post_flush_miss", {31'd0, stall}, 32'd1);
      fill(32'h0, 0, 32'h0, -1);
      expect_hit("post_flush_fill", 32'h0);

      // flush during REFILL: filled line stays invalid
      step(32'h40);
      fill(32'h40, 0, 32'h40, 2);
      step(32'h40);
      chk("kill_miss", {31'd0, stall}, 32'd1);
      fill(32'h40, 0, 32'h40, -1);
      expect_hit("kill_refill", 32'h40);

      // flush coincident with the final rvalid
      step(32'h80);
      fill(32'h80, 0, 32'h80, 3);
      step(32'h80);
      chk("flush_last_miss", {31'd0, stall}, 32'd1);

      // reset while REFILL counter is 2
      next();
      chk("rr_addr0", mem_addr, 32'h80);
      next();
      chk("rr_addr1", mem_addr, 32'h84);
      next();
      chk("rr_addr2", mem_addr, 32'h88);
      reset = 1'b0;
      #1;
      chk("rr_stall", {31'd0, stall}, 32'd1);
      chk("rr_instr", instr, 32'd0);
      next();
      reset = 1'b1;
      pc    = 32'h40;
      #1;
      chk("rr_req", {31'd0, mem_req}, 32'd0);
      chk("rr_addr", mem_addr, 32'd0);
      fill(32'h40, 0, 32'h40, -1);
      step(32'h0);
      chk("rr_miss0", {31'd0, stall}, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
